// File: rtl/alu_seq.sv
// Clocked 8-operation ALU with registered result, valid/ready handshake and
// an iterative shift-add multiplier that holds off new operands while it runs.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           sel,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   y,
  output logic                 zero
);

  localparam int unsigned YW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    ITERS   = CW'(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e          state_q, state_d;
  logic [YW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [YW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [YW-1:0]   y_q, y_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] shamt;
  logic [YW-1:0]    alu_res;
  logic [YW-1:0]    acc_step;

  assign add_w = {1'b0, A} + {1'b0, B};
  // The extra MSB of the widened difference is the borrow (set exactly when A < B).
  assign sub_w = {1'b0, A} - {1'b0, B};
  assign shamt = B % WIDTH_W;

  always_comb begin
    alu_res = '0;
    case (sel)
      OP_ADD: alu_res[WIDTH:0]   = add_w;
      OP_SUB: alu_res[WIDTH:0]   = sub_w;
      OP_AND: alu_res[WIDTH-1:0] = A & B;
      OP_OR:  alu_res[WIDTH-1:0] = A | B;
      OP_XOR: alu_res[WIDTH-1:0] = A ^ B;
      OP_SHL: alu_res            = {{WIDTH{1'b0}}, A} << shamt;
      OP_CMP: begin
        alu_res[0] = (A < B);
        alu_res[1] = (A == B);
        alu_res[2] = (A > B);
      end
      default: alu_res = '0;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (sel == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = ITERS;
            state_d  = S_MUL;
          end else begin
            y_d         = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // WIDTH step edges bring the counter to zero; the following edge publishes.
        if (cnt_q == '0) begin
          y_d         = acc_q;
          zero_d      = (acc_q == '0);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): scoreboard of expected {zero,y} pushed on accept,
// popped by a negedge monitor on every out_valid.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic [2:0]      sel;
  logic            out_valid;
  logic [2*W-1:0]  y;
  logic            zero;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .y         (y),
    .zero      (zero)
  );

  int tests_run = 0;
  int fails     = 0;
  int accepts   = 0;
  int outs      = 0;
  logic [16:0] sb[$];
  logic [15:0] prev_y;
  logic        prev_zero;
  logic        rst_edge;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [15:0] r;
    r = '0;
    case (op)
      3'd0: r = {7'd0, ({1'b0, a} + {1'b0, b})};
      3'd1: begin r[7:0] = a - b; r[8] = (a < b); end
      3'd2: r[7:0] = a & b;
      3'd3: r[7:0] = a | b;
      3'd4: r[7:0] = a ^ b;
      3'd5: r = 16'(a) * 16'(b);
      3'd6: r = 16'(a) << (b % 8);
      default: begin r[0] = (a < b); r[1] = (a == b); r[2] = (a > b); end
    endcase
    return {(r == 16'd0), r};
  endfunction

  always @(posedge clk) rst_edge = reset;

  always @(negedge clk) begin
    logic [16:0] exp;
    if (out_valid === 1'b1) begin
      outs++;
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: out_valid with y=%h zero=%b, required no result", y, zero);
      end else begin
        exp = sb.pop_front();
        if ({zero, y} !== exp) begin
          fails++;
          $display("FAIL result: y=%h zero=%b, required y=%h zero=%b", y, zero, exp[15:0], exp[16]);
        end
      end
    end else if (rst_edge === 1'b0) begin
      tests_run++;
      if (y !== prev_y || zero !== prev_zero) begin
        fails++;
        $display("FAIL hold: y=%h zero=%b changed without out_valid, required y=%h zero=%b",
                 y, zero, prev_y, prev_zero);
      end
    end
    prev_y    = y;
    prev_zero = zero;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      output int stalls);
    A = a; B = b; sel = op; in_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 64) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests_run++; fails++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 64 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, op));
    accepts++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; A = 8'hFF; B = 8'hFF; sel = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (y !== 16'h0 || zero !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: y=%h zero=%b out_valid=%b, required 0 0 0", y, zero, out_valid);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub;
    logic [7:0] av [3] = '{8'hFF, 8'h03, 8'h05};
    logic [7:0] bv [3] = '{8'h01, 8'h05, 8'h05};
    logic [2:0] ov [3] = '{3'b000, 3'b001, 3'b001};
    logic [16:0] ev [3] = '{{1'b0, 16'h0100}, {1'b0, 16'h01FE}, {1'b1, 16'h0000}};
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (model(av[i], bv[i], ov[i]) !== ev[i]) begin
        fails++;
        $display("FAIL model_addsub%0d: model=%h, required %h", i, model(av[i], bv[i], ov[i]), ev[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      A = av[i]; B = bv[i]; sel = ov[i]; in_valid = 1'b1;
      sb.push_back(ev[i]);
      accepts++;
      @(posedge clk); #1;
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL addsub_b2b%0d: out_valid=%b in_ready=%b, required 1 1", i, out_valid, in_ready);
      end
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL addsub_pulse_end: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_stall;
    int st;
    int n;
    send(8'hFF, 8'hFF, 3'b101, st);
    A = 8'h12; B = 8'h34; sel = 3'b000; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      n++;
      tests_run++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mul_early_valid: out_valid=%b in stall cycle %0d, required 0", out_valid, n);
      end
      @(negedge clk);
    end
    tests_run++;
    if (n != W + 1) begin
      fails++;
      $display("FAIL mul_stall_len: in_ready low for %0d cycles, required %0d", n, W + 1);
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mul_result_cycle: out_valid=%b when in_ready returns, required 1", out_valid);
    end
    sb.push_back(model(8'h12, 8'h34, 3'b000));
    accepts++;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 64) begin @(negedge clk); n++; end
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL mul_drain: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_logic_shift_cmp;
    int st;
    int n;
    send(8'h81, 8'h09, 3'b110, st);
    send(8'h10, 8'h20, 3'b111, st);
    send(8'hF0, 8'h3C, 3'b010, st);
    send(8'hF0, 8'h3C, 3'b011, st);
    send(8'hF0, 8'h3C, 3'b100, st);
    tests_run++;
    if (model(8'h81, 8'h09, 3'b110) !== {1'b0, 16'h0102} ||
        model(8'h10, 8'h20, 3'b111) !== {1'b0, 16'h0001} ||
        model(8'hF0, 8'h3C, 3'b100) !== {1'b0, 16'h00CC}) begin
      fails++;
      $display("FAIL model_logic: model disagrees with hand values 0102/0001/00CC");
    end
    n = 0;
    while (sb.size() != 0 && n < 64) begin @(negedge clk); n++; end
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL logic_drain: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    int st;
    int n;
    send(8'h0F, 8'h0F, 3'b101, st);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    accepts--;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || y !== 16'h0 || zero !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_mul_reset: out_valid=%b y=%h zero=%b in_ready=%b, required 0 0000 0 1",
               out_valid, y, zero, in_ready);
    end
    repeat (12) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_mul_aborted: out_valid=%b after abort, required 0", out_valid);
      end
    end
    @(posedge clk); #1;
    send(8'h02, 8'h03, 3'b101, st);
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 64) begin n++; @(negedge clk); end
    tests_run++;
    if (n != W + 1) begin
      fails++;
      $display("FAIL mul_latency: out_valid after %0d idle cycles, required %0d", n, W + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int st;
    int n;
    int acc0;
    int out0;
    acc0 = accepts;
    out0 = outs;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), st);
    end
    n = 0;
    while (sb.size() != 0 && n < 64) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    tests_run++;
    if ((outs - out0) != (accepts - acc0) || sb.size() != 0) begin
      fails++;
      $display("FAIL random_count: out_valid count=%0d, required accept count %0d",
               outs - out0, accepts - acc0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0;
    test_reset();
    test_add_sub();
    test_mul_stall();
    test_logic_shift_cmp();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
